// File: rtl/ad9228_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ad9228_pkg
// Brief   : Shared types and helpers for the AD9228 multi-channel capture path
// Revision: 1.0 - initial release
// ============================================================================
package ad9228_pkg;

    localparam int DEFAULT_DATA_WIDTH = 12;
    localparam int DEFAULT_NUM_CH     = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PREFILL = 3'd1,
        ARMED   = 3'd2,
        POST    = 3'd3,
        READOUT = 3'd4
    } capture_state_t;

    // Index width that never collapses to zero for a single-entry range.
    function automatic int clog2_min1(input int value);
        int result;
        result = (value <= 2) ? 1 : $clog2(value);
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ad9228_capture_ram.sv
`default_nettype none
// ============================================================================
// Module  : ad9228_capture_ram
// Brief   : Simple dual-port RAM, one write port, one registered read port
// Revision: 1.0 - initial release
// ============================================================================
module ad9228_capture_ram #(
    parameter int WIDTH  = 48,
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read data holds when rd_en is low; the readout pipeline relies on this.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ad9228_multi_ch_trig_capture.sv
`default_nettype none
// ============================================================================
// Module  : ad9228_multi_ch_trig_capture
// Brief   : Multi-channel pre/post-trigger capture with interleaved stream drain.
//           Optional trigger timestamp: define AD9228_TRIG_TIMESTAMP_EN.
// Revision: 1.0 - initial release
// ============================================================================
module ad9228_multi_ch_trig_capture
    import ad9228_pkg::*;
#(
    parameter  int NUM_CH     = DEFAULT_NUM_CH,
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int DEPTH      = 2048,
    parameter  int TS_WIDTH   = 32,
    localparam int ADDR_W     = $clog2(DEPTH),
    localparam int CH_W       = clog2_min1(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] din,
    input  logic                         din_valid,
    input  logic                         arm,
    input  logic                         abort,
    input  logic                         force_trig,
    input  logic [NUM_CH-1:0]            trig_ch_mask,
    input  logic [DATA_WIDTH-1:0]        trig_level,
    input  logic                         trig_rising,
    input  logic [ADDR_W-1:0]            pre_len,
    input  logic [ADDR_W-1:0]            post_len,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic [CH_W-1:0]              m_ch,
    output logic                         m_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         busy,
    output logic                         triggered,
    output logic [TS_WIDTH-1:0]          trig_ts
);

    localparam int                W          = NUM_CH * DATA_WIDTH;
    localparam logic [ADDR_W-1:0] C_ADDR_MAX = ADDR_W'(DEPTH - 1);
    localparam logic [CH_W-1:0]   C_CH_LAST  = CH_W'(NUM_CH - 1);

    capture_state_t          r_state;
    logic [ADDR_W-1:0]       r_wr_ptr;
    logic [ADDR_W-1:0]       r_pre_len;
    logic [ADDR_W-1:0]       r_post_eff;
    logic [ADDR_W-1:0]       r_cnt;
    logic [ADDR_W-1:0]       r_rd_addr;
    logic [ADDR_W:0]         r_rd_left;
    logic [DATA_WIDTH-1:0]   r_level;
    logic                    r_rising;
    logic [NUM_CH-1:0]       r_mask;
    logic [W-1:0]            r_prev;
    logic                    r_prev_valid;
    logic                    r_force_pend;
    logic                    r_triggered;
    logic                    r_s1_valid;
    logic                    r_s1_last;
    logic                    r_out_valid;
    logic                    r_out_last;
    logic [W-1:0]            r_word;
    logic [CH_W-1:0]         r_ch;

    logic [ADDR_W-1:0]       w_room;
    logic [ADDR_W-1:0]       w_post_eff;
    logic [ADDR_W:0]         w_rec_len;
    logic [NUM_CH-1:0]       w_fire_vec;
    logic                    w_trig;
    logic                    w_wr_en;
    logic                    w_xfer;
    logic                    w_s2_free;
    logic                    w_s2_load;
    logic                    w_rd_issue;
    logic [W-1:0]            w_rd_data;
    logic [DATA_WIDTH-1:0]   w_m_data;

    // Post length is clipped so the whole record fits in one buffer revolution.
    assign w_room     = C_ADDR_MAX - pre_len;
    assign w_post_eff = (post_len < w_room) ? post_len : w_room;
    assign w_rec_len  = {1'b0, r_pre_len} + {1'b0, r_post_eff} + (ADDR_W+1)'(1);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_trig
        logic [DATA_WIDTH-1:0] w_cur;
        logic [DATA_WIDTH-1:0] w_prv;
        assign w_cur = din[c*DATA_WIDTH +: DATA_WIDTH];
        assign w_prv = r_prev[c*DATA_WIDTH +: DATA_WIDTH];
        assign w_fire_vec[c] = r_mask[c] & (r_rising ? ((w_prv <  r_level) && (w_cur >= r_level))
                                                     : ((w_prv >= r_level) && (w_cur <  r_level)));
    end

    assign w_trig  = (r_state == ARMED) && din_valid &&
                     ((r_prev_valid && (|w_fire_vec)) || force_trig || r_force_pend);
    assign w_wr_en = din_valid && (r_state inside {PREFILL, ARMED, POST});

    // Two-stage readout: RAM output register (s1) feeds the per-sample output word.
    assign w_xfer     = r_out_valid && m_ready;
    assign w_s2_free  = !r_out_valid || (w_xfer && (r_ch == C_CH_LAST));
    assign w_s2_load  = r_s1_valid && w_s2_free;
    assign w_rd_issue = (r_state == READOUT) && (r_rd_left != '0) && (!r_s1_valid || w_s2_load);

    ad9228_capture_ram #(
        .WIDTH  (W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_addr (r_wr_ptr),
        .wr_data (din),
        .rd_en   (w_rd_issue),
        .rd_addr (r_rd_addr),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_pre_len    <= '0;
            r_post_eff   <= '0;
            r_cnt        <= '0;
            r_rd_addr    <= '0;
            r_rd_left    <= '0;
            r_level      <= '0;
            r_rising     <= 1'b0;
            r_mask       <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_force_pend <= 1'b0;
            r_triggered  <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_word       <= '0;
            r_ch         <= '0;
        end else if (abort) begin
            r_state      <= IDLE;
            r_triggered  <= 1'b0;
            r_force_pend <= 1'b0;
            r_rd_left    <= '0;
            r_s1_valid   <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr     <= r_wr_ptr + 1'b1;
                r_prev       <= din;
                r_prev_valid <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (arm) begin
                        r_pre_len    <= pre_len;
                        r_post_eff   <= w_post_eff;
                        r_level      <= trig_level;
                        r_rising     <= trig_rising;
                        r_mask       <= trig_ch_mask;
                        r_prev_valid <= 1'b0;
                        r_force_pend <= 1'b0;
                        r_cnt        <= '0;
                        r_state      <= (pre_len == '0) ? ARMED : PREFILL;
                    end
                end
                PREFILL: begin
                    if (din_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == r_pre_len - 1'b1) begin
                            r_state <= ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (w_trig) begin
                        r_triggered  <= 1'b1;
                        r_force_pend <= 1'b0;
                        r_cnt        <= '0;
                        r_rd_addr    <= r_wr_ptr - r_pre_len;
                        r_rd_left    <= w_rec_len;
                        r_state      <= (r_post_eff == '0) ? READOUT : POST;
                    end else if (force_trig) begin
                        r_force_pend <= 1'b1;
                    end
                end
                POST: begin
                    if (din_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == r_post_eff - 1'b1) begin
                            r_state <= READOUT;
                        end
                    end
                end
                READOUT: begin
                    if (w_rd_issue) begin
                        r_rd_addr  <= r_rd_addr + 1'b1;
                        r_rd_left  <= r_rd_left - 1'b1;
                        r_s1_valid <= 1'b1;
                        r_s1_last  <= (r_rd_left == (ADDR_W+1)'(1));
                    end else if (w_s2_load) begin
                        r_s1_valid <= 1'b0;
                    end
                    if (w_s2_load) begin
                        r_word      <= w_rd_data;
                        r_out_last  <= r_s1_last;
                        r_out_valid <= 1'b1;
                        r_ch        <= '0;
                    end else if (w_xfer) begin
                        if (r_ch == C_CH_LAST) begin
                            r_out_valid <= 1'b0;
                        end else begin
                            r_ch <= r_ch + 1'b1;
                        end
                    end
                    if (w_xfer && r_out_last && (r_ch == C_CH_LAST)) begin
                        r_state     <= IDLE;
                        r_triggered <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_m_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_ch == CH_W'(c)) begin
                w_m_data = r_word[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign m_data    = w_m_data;
    assign m_ch      = r_ch;
    assign m_valid   = r_out_valid;
    assign m_last    = r_out_valid && r_out_last && (r_ch == C_CH_LAST);
    assign busy      = (r_state != IDLE);
    assign triggered = r_triggered;

`ifdef AD9228_TRIG_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] r_ts_cnt;
    logic [TS_WIDTH-1:0] r_trig_ts;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts_cnt  <= '0;
            r_trig_ts <= '0;
        end else begin
            if (din_valid) begin
                r_ts_cnt <= r_ts_cnt + 1'b1;
            end
            if (w_trig && !abort) begin
                r_trig_ts <= r_ts_cnt;
            end
        end
    end

    assign trig_ts = r_trig_ts;
`else
    assign trig_ts = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ad9228_multi_ch_trig_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_ad9228_multi_ch_trig_capture
// Brief   : Scoreboard bench for the multi-channel trigger capture block
// Revision: 1.0 - initial release
// ============================================================================
module tb_ad9228_multi_ch_trig_capture;

    localparam int NCH = 2;
    localparam int DW  = 12;
    localparam int DEP = 16;
    localparam int AW  = 4;
    localparam int TSW = 32;
`ifdef AD9228_TRIG_TIMESTAMP_EN
    localparam int EXP_TS = 24;
`else
    localparam int EXP_TS = 0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          ch;
        logic          last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH*DW-1:0] din = '0;
    logic              din_valid = 1'b0;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic              force_trig = 1'b0;
    logic [NCH-1:0]    trig_ch_mask = '0;
    logic [DW-1:0]     trig_level = '0;
    logic              trig_rising = 1'b0;
    logic [AW-1:0]     pre_len = '0;
    logic [AW-1:0]     post_len = '0;
    logic [DW-1:0]     m_data;
    logic              m_ch;
    logic              m_last;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic              busy;
    logic              triggered;
    logic [TSW-1:0]    trig_ts;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   xfer_cnt = 0;
    int   ready_limit = 1 << 30;
    int   ready_toggle = 0;
    int   ready_phase = 0;
    int   v = 0;

    ad9228_multi_ch_trig_capture #(
        .NUM_CH(NCH), .DATA_WIDTH(DW), .DEPTH(DEP), .TS_WIDTH(TSW)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .arm(arm),
        .abort(abort), .force_trig(force_trig), .trig_ch_mask(trig_ch_mask),
        .trig_level(trig_level), .trig_rising(trig_rising), .pre_len(pre_len),
        .post_len(post_len), .m_data(m_data), .m_ch(m_ch), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .triggered(triggered),
        .trig_ts(trig_ts)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; pulses clear and m_ready follows the current pattern.
    task automatic step();
        @(posedge clk);
        #1;
        arm        = 1'b0;
        abort      = 1'b0;
        force_trig = 1'b0;
        din_valid  = 1'b0;
        if (ready_toggle != 0) begin
            m_ready = ((ready_phase % 3) == 0) && (xfer_cnt < ready_limit);
            ready_phase++;
        end else begin
            m_ready = (xfer_cnt < ready_limit);
        end
    endtask

    task automatic feed(input logic ft);
        din        = {DW'(v + 100), DW'(v)};
        din_valid  = 1'b1;
        force_trig = ft;
        v++;
        step();
    endtask

    task automatic set_cfg(input int pre, input int post, input int level,
                           input logic rising, input logic [NCH-1:0] mask);
        pre_len      = AW'(pre);
        post_len     = AW'(post);
        trig_level   = DW'(level);
        trig_rising  = rising;
        trig_ch_mask = mask;
    endtask

    // Ch0 carries sample value s, ch1 carries s+100.
    task automatic push_record(input int first, input int n, input int max_words);
        exp_t e;
        int   k;
        k = 0;
        for (int s = first; s < first + n; s++) begin
            for (int c = 0; c < NCH; c++) begin
                if (k < max_words) begin
                    e.data = DW'(s + 100 * c);
                    e.ch   = 1'(c);
                    e.last = (s == first + n - 1) && (c == NCH - 1);
                    exp_q.push_back(e);
                end
                k++;
            end
        end
    endtask

    task automatic run_until_idle(input string name, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            feed(1'b0);
            n++;
        end
        check({name, "_idle"}, 64'(busy), 64'd0);
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({name, "_trig_clear"}, 64'(triggered), 64'd0);
    endtask

    // Monitor: pops expected words on transfers, checks holds during stalls.
    initial begin
        logic          stall_q;
        logic          abort_q;
        logic [DW-1:0] p_data;
        logic          p_ch;
        logic          p_last;
        exp_t          e;
        stall_q = 1'b0;
        abort_q = 1'b0;
        p_data  = '0;
        p_ch    = 1'b0;
        p_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (stall_q && !abort_q) begin
                check("stall_hold", {m_valid, m_data, m_ch, m_last}, {1'b1, p_data, p_ch, p_last});
            end
            if (m_valid && m_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got data=%0d ch=%0d last=%0d, expected none",
                             m_data, m_ch, m_last);
                end else begin
                    e = exp_q.pop_front();
                    check("word", {m_data, m_ch, m_last}, {e.data, e.ch, e.last});
                end
            end
            stall_q = m_valid && !m_ready;
            abort_q = abort || rst;
            p_data  = m_data;
            p_ch    = m_ch;
            p_last  = m_last;
        end
    end

    initial begin
        int n;
        repeat (3) step();
        check("rst_outputs", {m_valid, m_last, busy, triggered, m_data, m_ch}, '0);
        check("rst_ts", 64'(trig_ts), 64'd0);
        rst = 1'b0;
        step();
        check("post_rst_busy", 64'(busy), 64'd0);

        // Ramp, rising level 10 on ch0: trigger on sample 10, record 6..13.
        set_cfg(4, 3, 10, 1'b1, 2'b01);
        v = 0;
        push_record(6, 8, 16);
        arm = 1'b1;
        step();
        repeat (10) feed(1'b0);
        check("t1_not_yet", 64'(triggered), 64'd0);
        feed(1'b0);
        check("t1_triggered", 64'(triggered), 64'd1);
        run_until_idle("t1", 200);

        // Same capture, consumer stalls two cycles of every three.
        ready_toggle = 1;
        v = 0;
        push_record(6, 8, 16);
        arm = 1'b1;
        step();
        run_until_idle("t2", 300);
        ready_toggle = 0;

        // Pre 12 / post 10 in a 16-deep buffer: post clipped to 3, record wraps.
        set_cfg(12, 10, 40, 1'b1, 2'b01);
        v = 0;
        push_record(28, 16, 32);
        arm = 1'b1;
        step();
        run_until_idle("t3", 300);

        // Level already above threshold; force in PREFILL ignored, in ARMED honoured.
        set_cfg(4, 2, 5, 1'b1, 2'b01);
        v = 20;
        push_record(26, 7, 14);
        arm = 1'b1;
        step();
        feed(1'b1);
        repeat (9) feed(1'b0);
        check("t4_no_trig", 64'(triggered), 64'd0);
        check("t4_busy", 64'(busy), 64'd1);
        feed(1'b1);
        check("t4_force", 64'(triggered), 64'd1);
        run_until_idle("t4", 200);

        // Abort after five words, then a clean re-capture.
        set_cfg(4, 3, 10, 1'b1, 2'b01);
        v = 0;
        xfer_cnt = 0;
        ready_limit = 5;
        push_record(6, 8, 5);
        arm = 1'b1;
        step();
        n = 0;
        while (xfer_cnt < 5 && n < 200) begin
            feed(1'b0);
            n++;
        end
        check("t5_words_before_abort", 64'(xfer_cnt), 64'd5);
        abort = 1'b1;
        step();
        check("t5_abort_state", {m_valid, busy, triggered}, 64'd0);
        check("t5_queue", 64'(exp_q.size()), 64'd0);
        ready_limit = 1 << 30;
        step();
        v = 0;
        push_record(6, 8, 16);
        arm = 1'b1;
        step();
        run_until_idle("t5_rearm", 200);

        // Valid every other cycle; force on the 25th valid sample after reset.
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        set_cfg(4, 2, 0, 1'b1, 2'b00);
        v = 0;
        push_record(20, 7, 14);
        arm = 1'b1;
        step();
        for (int k = 0; k < 25; k++) begin
            feed(k == 24);
            if (k == 24) begin
                check("t6_triggered", 64'(triggered), 64'd1);
                check("t6_trig_ts", 64'(trig_ts), 64'(EXP_TS));
            end
            step();
        end
        run_until_idle("t6", 200);
        check("t6_ts_hold", 64'(trig_ts), 64'(EXP_TS));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
